// File: rtl/chip_seq_pkg.sv
// ============================================================================
//  Module   : chip_seq_pkg
//  Purpose  : Shared types, constants and helpers for the ChIP valve sequencer
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package chip_seq_pkg;

    // Host-visible operation codes; 6 and 7 are illegal.
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LOAD    = 3'd1,
        OP_BEAD    = 3'd2,
        OP_MIX_FWD = 3'd3,
        OP_MIX_REV = 3'd4,
        OP_WASH    = 3'd5
    } op_e;

    // Sequencer states; the guard states are only reachable with CHIP_BBM_GUARD_EN.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_HOLD       = 3'd1,
        ST_PUMP       = 3'd2,
        ST_GUARD_PRE  = 3'd3,
        ST_GUARD_POST = 3'd4
    } state_e;

    // Valve air lines in port order (first member is the MSB); 1 = closed.
    typedef struct packed {
        logic ring_in_ctrl;
        logic ring_out_ctrl;
        logic sieve_ctrl;
        logic collect_ctrl;
        logic inlet_ctrl;
        logic outlet_ctrl;
        logic bead_ctrl;
        logic pump1;
        logic pump2;
        logic pump3;
    } valve_vec_t;

    localparam valve_vec_t VALVES_CLOSED = '1;

    // Peristaltic phases {pump1,pump2,pump3}; entry 0 is the first forward phase.
    localparam logic [5:0][2:0] PUMP_PHASES = {
        3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011
    };

    localparam logic [2:0] PHASE_FIRST = 3'd0;
    localparam logic [2:0] PHASE_LAST  = 3'd5;

    // Table lookup with constant indices; out-of-range indices give all-closed.
    function automatic logic [2:0] pump_pattern(input logic [2:0] idx);
        logic [2:0] pat;
        case (idx)
            3'd0:    pat = PUMP_PHASES[0];
            3'd1:    pat = PUMP_PHASES[1];
            3'd2:    pat = PUMP_PHASES[2];
            3'd3:    pat = PUMP_PHASES[3];
            3'd4:    pat = PUMP_PHASES[4];
            3'd5:    pat = PUMP_PHASES[5];
            default: pat = 3'b111;
        endcase
        return pat;
    endfunction

    // Static valve pattern for the hold-type operations.
    function automatic valve_vec_t hold_pattern(input logic [2:0] op);
        valve_vec_t v;
        v = VALVES_CLOSED;
        case (op)
            OP_LOAD: begin
                v.inlet_ctrl  = 1'b0;
                v.outlet_ctrl = 1'b0;
            end
            OP_BEAD: begin
                v.bead_ctrl   = 1'b0;
                v.outlet_ctrl = 1'b0;
            end
            OP_WASH: begin
                v.ring_in_ctrl  = 1'b0;
                v.ring_out_ctrl = 1'b0;
                v.sieve_ctrl    = 1'b0;
                v.collect_ctrl  = 1'b0;
            end
            default: v = VALVES_CLOSED;
        endcase
        return v;
    endfunction

    function automatic logic op_is_mix(input logic [2:0] op);
        return (op == OP_MIX_FWD) || (op == OP_MIX_REV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/chip_peristaltic_gen.sv
// ============================================================================
//  Module   : chip_peristaltic_gen
//  Purpose  : 6-phase peristaltic pump stepper. Exposes the pattern for the
//             next cycle so the caller can register it alongside other valves,
//             and flags the final cycle of the final revolution.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module chip_peristaltic_gen
    import chip_seq_pkg::*;
#(
    parameter int ARG_W        = 16,
    parameter int DWELL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [ARG_W-1:0] revs,
    output logic [2:0]       pattern_next,
    output logic             last
);

    localparam int             DW           = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0]  DWELL_RELOAD = DW'(DWELL_CYCLES - 1);

    logic             active, active_d;
    logic             dir_q, dir_d;
    logic [2:0]       phase, phase_d;
    logic [DW-1:0]    dwell, dwell_d;
    logic [ARG_W-1:0] rev, rev_d;
    logic             at_end;

    // A revolution ends on phase 5 going forward, phase 0 going in reverse.
    assign at_end = (phase == (dir_q ? PHASE_FIRST : PHASE_LAST));
    assign last   = active && (dwell == '0) && at_end && (rev == '0);

    // Next-state: start loads, stop parks, otherwise dwell then step the phase.
    always_comb begin
        active_d = active;
        dir_d    = dir_q;
        phase_d  = phase;
        dwell_d  = dwell;
        rev_d    = rev;
        if (start) begin
            active_d = 1'b1;
            dir_d    = dir;
            phase_d  = dir ? PHASE_LAST : PHASE_FIRST;
            dwell_d  = DWELL_RELOAD;
            rev_d    = revs - 1'b1;
        end else if (stop) begin
            active_d = 1'b0;
        end else if (active) begin
            if (dwell != '0) begin
                dwell_d = dwell - 1'b1;
            end else begin
                dwell_d = DWELL_RELOAD;
                if (at_end) begin
                    if (rev == '0) begin
                        active_d = 1'b0;
                    end else begin
                        rev_d = rev - 1'b1;
                    end
                end
                if (dir_q) begin
                    phase_d = (phase == PHASE_FIRST) ? PHASE_LAST : phase - 3'd1;
                end else begin
                    phase_d = (phase == PHASE_LAST) ? PHASE_FIRST : phase + 3'd1;
                end
            end
        end
    end

    assign pattern_next = pump_pattern(phase_d);

    // Stepper state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            dir_q  <= 1'b0;
            phase  <= PHASE_FIRST;
            dwell  <= '0;
            rev    <= '0;
        end else begin
            active <= active_d;
            dir_q  <= dir_d;
            phase  <= phase_d;
            dwell  <= dwell_d;
            rev    <= rev_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/chip_valve_sequencer.sv
// ============================================================================
//  Module   : chip_valve_sequencer
//  Purpose  : Accepts one valve operation at a time and drives timed valve
//             patterns (static holds or a peristaltic pump drive) to the
//             ChIP chamber's solenoid bank. All outputs are registered.
//  Options  : CHIP_BBM_GUARD_EN - inserts GUARD_CYCLES of all-closed before
//             and after each pattern (break-before-make). GUARD_CYCLES must
//             be >= 1 when enabled.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module chip_valve_sequencer
    import chip_seq_pkg::*;
#(
    parameter int ARG_W        = 16,
    parameter int DWELL_CYCLES = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ring_in_ctrl,
    output logic             ring_out_ctrl,
    output logic             sieve_ctrl,
    output logic             collect_ctrl,
    output logic             inlet_ctrl,
    output logic             outlet_ctrl,
    output logic             bead_ctrl,
    output logic             pump1,
    output logic             pump2,
    output logic             pump3
);

    state_e           state, state_d;
    valve_vec_t       valves, valves_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [ARG_W-1:0] cnt, cnt_d;
    logic             launch;
    logic             finish;
    logic [2:0]       start_op;
    logic [ARG_W-1:0] start_arg;
    logic             gen_start;
    logic             gen_last;
    logic [2:0]       gen_pattern;

`ifdef CHIP_BBM_GUARD_EN
    localparam int            GW           = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_RELOAD = GW'(GUARD_CYCLES - 1);

    logic [2:0]       op_q, op_d;
    logic [ARG_W-1:0] arg_q, arg_d;
    logic [GW-1:0]    gcnt, gcnt_d;

    // The pattern starts once the leading guard gap has elapsed.
    assign start_op  = op_q;
    assign start_arg = arg_q;
    assign launch    = (state == ST_GUARD_PRE) && (gcnt == '0) && !abort;
`else
    // The pattern starts directly on acceptance of a legal, non-empty op.
    assign start_op  = cmd_op;
    assign start_arg = cmd_arg;
    assign launch    = (state == ST_IDLE) && cmd_valid && (cmd_op != OP_NOP)
                       && (cmd_op <= OP_WASH) && (cmd_arg != '0);
`endif

    assign gen_start = launch && op_is_mix(start_op);

    chip_peristaltic_gen #(
        .ARG_W        (ARG_W),
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_pump (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (gen_start),
        .stop         (abort),
        .dir          (start_op == OP_MIX_REV),
        .revs         (start_arg),
        .pattern_next (gen_pattern),
        .last         (gen_last)
    );

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d  = state;
        valves_d = valves;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt;
        finish   = 1'b0;
`ifdef CHIP_BBM_GUARD_EN
        op_d     = op_q;
        arg_d    = arg_q;
        gcnt_d   = gcnt;
`endif
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op > OP_WASH) begin
                        err_d = 1'b1;
                    end else if ((cmd_op == OP_NOP) || (cmd_arg == '0)) begin
                        done_d = 1'b1;
                    end
`ifdef CHIP_BBM_GUARD_EN
                    else begin
                        state_d = ST_GUARD_PRE;
                        gcnt_d  = GUARD_RELOAD;
                        op_d    = cmd_op;
                        arg_d   = cmd_arg;
                    end
`endif
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_PUMP: begin
                {valves_d.pump1, valves_d.pump2, valves_d.pump3} = gen_pattern;
                if (gen_last) begin
                    finish = 1'b1;
                end
            end
`ifdef CHIP_BBM_GUARD_EN
            ST_GUARD_PRE: begin
                if (gcnt != '0) begin
                    gcnt_d = gcnt - 1'b1;
                end
            end
            ST_GUARD_POST: begin
                if (gcnt == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt - 1'b1;
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                valves_d = VALVES_CLOSED;
            end
        endcase

        if (launch) begin
            if (op_is_mix(start_op)) begin
                state_d  = ST_PUMP;
                valves_d = VALVES_CLOSED;
                {valves_d.pump1, valves_d.pump2, valves_d.pump3} = gen_pattern;
            end else begin
                state_d  = ST_HOLD;
                valves_d = hold_pattern(start_op);
                cnt_d    = start_arg - 1'b1;
            end
        end

        if (finish) begin
            valves_d = VALVES_CLOSED;
`ifdef CHIP_BBM_GUARD_EN
            state_d  = ST_GUARD_POST;
            gcnt_d   = GUARD_RELOAD;
`else
            state_d  = ST_IDLE;
            done_d   = 1'b1;
`endif
        end

        if (abort && (state != ST_IDLE)) begin
            state_d  = ST_IDLE;
            valves_d = VALVES_CLOSED;
            done_d   = 1'b0;
            err_d    = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            valves <= VALVES_CLOSED;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_d;
            valves <= valves_d;
            done_q <= done_d;
            err_q  <= err_d;
            cnt    <= cnt_d;
        end
    end

`ifdef CHIP_BBM_GUARD_EN
    // Latched command and guard-gap counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= OP_NOP;
            arg_q <= '0;
            gcnt  <= '0;
        end else begin
            op_q  <= op_d;
            arg_q <= arg_d;
            gcnt  <= gcnt_d;
        end
    end
`endif

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign ring_in_ctrl  = valves.ring_in_ctrl;
    assign ring_out_ctrl = valves.ring_out_ctrl;
    assign sieve_ctrl    = valves.sieve_ctrl;
    assign collect_ctrl  = valves.collect_ctrl;
    assign inlet_ctrl    = valves.inlet_ctrl;
    assign outlet_ctrl   = valves.outlet_ctrl;
    assign bead_ctrl     = valves.bead_ctrl;
    assign pump1         = valves.pump1;
    assign pump2         = valves.pump2;
    assign pump3         = valves.pump3;

    // Inlet and bead lines must never be open together.
    a_interlock: assert property (@(posedge clk) disable iff (!rst_n)
                                  (valves.inlet_ctrl || valves.bead_ctrl));

    // Parameter sanity: a phase must last at least one cycle, a guard gap at least one.
    a_params: assert property (@(posedge clk)
                               (DWELL_CYCLES >= 1) && (GUARD_CYCLES >= 1));

endmodule

`default_nettype wire

// File: doc/chip_valve_sequencer.md
Name: chip_valve_sequencer

Overview:
- Pneumatic-side driver for the ChIP chamber's valve control lines.
- Accepts one valve-operation command at a time over a valid/ready port and steps through timed valve patterns.
- Patterns include a 6-phase peristaltic drive of pump1/pump2/pump3.
- Sits between the host command path and the off-chip solenoid bank feeding the chamber's air_in lines.

Parameters:
- ARG_W, 16: width of the command argument (hold cycles or pump revolutions).
- DWELL_CYCLES, 4: clock cycles each peristaltic phase is held; must be >= 1.
- GUARD_CYCLES, 2: all-closed gap length; used only with CHIP_BBM_GUARD_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  operation code.
- cmd_arg  input  ARG_W  hold cycles, or pump revolutions for MIX ops.
- abort  input  1  synchronous abort.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse on illegal op or abort.
- ring_in_ctrl, ring_out_ctrl, sieve_ctrl, collect_ctrl, inlet_ctrl, outlet_ctrl, bead_ctrl, pump1, pump2, pump3  output  1 each  valve air lines; 1 = pressurized = valve closed.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - All ten valve outputs = 1 (all closed).
  - busy = 0, done = 0, err = 0, cmd_ready = 1.
  - State = IDLE.
- Handshake:
  - cmd_ready = (state == IDLE).
  - A command is accepted when cmd_valid && cmd_ready; op and arg are latched.
  - All outputs are registered. The valve pattern appears the cycle after acceptance.
- Op codes (valves listed are opened, i.e. driven 0; all others stay 1):
  - 0 NOP: no valve change; done pulses the cycle after acceptance.
  - 1 LOAD: inlet_ctrl, outlet_ctrl open; hold for arg cycles.
  - 2 BEAD: bead_ctrl, outlet_ctrl open; hold for arg cycles.
  - 3 MIX_FWD: ports closed; pump runs arg revolutions forward.
  - 4 MIX_REV: same as MIX_FWD, phase order reversed.
  - 5 WASH: ring_in_ctrl, ring_out_ctrl, sieve_ctrl, collect_ctrl open; hold for arg cycles.
  - 6, 7: illegal. err pulses the cycle after acceptance; valves unchanged; returns to IDLE.
- States: IDLE -> HOLD or PUMP -> IDLE. With the macro, GUARD is inserted before and after HOLD/PUMP.
- HOLD:
  - The pattern is driven for exactly arg cycles.
  - The cycle after the last hold cycle: all valves = 1 and done = 1 together; state returns to IDLE.
- PUMP, phase pattern {pump1, pump2, pump3}:
  - Forward: 011, 001, 101, 100, 110, 010.
  - Reverse walks the same list backwards, starting at 010.
  - Each phase is held DWELL_CYCLES.
  - One revolution = 6 phases. Total = arg*6*DWELL_CYCLES cycles.
  - Completion behaves as for HOLD, with pumps returning to 111.
- arg == 0 on ops 1–5: treated as NOP; done the next cycle, no valve change.
- Counters:
  - Revolution counter is ARG_W bits; phase index is mod 6 and wraps 5->0 (forward) or 0->5 (reverse).
  - Dwell counter is sized by $clog2(DWELL_CYCLES+1).
  - None of the counters may wrap the arg count.
- Interlock: inlet_ctrl and bead_ctrl are never both 0 in the same cycle; this is asserted.
- abort:
  - In a non-IDLE state: next cycle all valves = 1, err = 1, done = 0, state = IDLE.
  - In IDLE: ignored.
  - abort together with cmd_valid in IDLE: the command is accepted normally.
- busy = (state != IDLE).
- rst_n low mid-operation: next cycle all outputs take their reset values.

Optional Feature:
- Macro CHIP_BBM_GUARD_EN (break-before-make).
- When defined:
  - GUARD_CYCLES of all-valves-closed are inserted between acceptance and the first pattern cycle.
  - The same gap is inserted before done.
  - Total latency grows by 2*GUARD_CYCLES.
  - NOP and illegal ops skip the guard.
  - abort during GUARD behaves as abort in any other non-IDLE state.
- When undefined: no GUARD state; timing exactly as above.

Decomposition:
- Package chip_seq_pkg holds:
  - op_e enum (NOP, LOAD, BEAD, MIX_FWD, MIX_REV, WASH).
  - state_e enum.
  - valve_vec_t: packed 10-bit struct in port order.
  - VALVES_CLOSED constant = all ones.
  - 6-entry pump phase table.
- One natural sub-module: chip_peristaltic_gen. Inputs: start, dir, revs, DWELL_CYCLES. Outputs: 3-bit pump pattern and a last flag.

Test Plan:
- Reset then LOAD arg=5 -> from cycle +1, inlet_ctrl = outlet_ctrl = 0 for exactly 5 cycles; next cycle all 1 and done = 1; cmd_ready is low throughout.
- MIX_FWD arg=2, DWELL_CYCLES=4 -> 48 pump cycles following the forward phase order, then pumps = 111 and done; MIX_REV arg=1 -> 010, 110, 100, 101, 001, 011.
- WASH arg=100, abort at cycle 10 -> cycle 11: all valves 1, err = 1, done never pulses; cmd_ready high at cycle 11.
- op=6 -> err pulse the next cycle, no valve toggles; LOAD arg=0 -> done the next cycle, no valve toggles.
- rst_n low during PUMP phase 3 -> next cycle all valves 1, busy = 0; with CHIP_BBM_GUARD_EN, LOAD arg=3, GUARD_CYCLES=2 -> 2 closed cycles, 3 open cycles, 2 closed cycles, then done.
- Back-to-back: cmd_valid held high with BEAD arg=1 then LOAD arg=1 -> second command accepted in the done cycle; bead and inlet are never open in the same cycle.
